rot_step_sequencer: RTL and testbench

- Upstream control stage for the parameterized right rotator.
- Captures a data word and drives it unchanged on a_out; produces a rotation amount on amt_out that steps automatically at a programmable rate.
- The rotator's output (the display word) therefore rotates continuously.
- Run/pause/direction are user controls, driven by single-cycle pulses from the board-level debounce logic.

---
 rtl/rot_step_sequencer_pkg.sv | 13 +
 rtl/rot_step_sequencer_if.sv | 30 +++
 rtl/rot_step_sequencer_tick_gen.sv | 39 +++
 rtl/rot_step_sequencer.sv | 95 +++++++++
 tb/tb_rot_step_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rot_step_sequencer_pkg.sv
// Shared types and default parameters for the rotation step sequencer.
package rot_seq_pkg;

    localparam int unsigned N_DEFAULT        = 3;
    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

endpackage

// File: rtl/rot_step_sequencer_if.sv
// Control/data bundle between the board-level controls and the sequencer.
// master = upstream driver of controls, slave = the sequencer itself.
interface rot_step_sequencer_if
    import rot_seq_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);

    logic              load;
    logic [2**N-1:0]   din;
    logic              start;
    logic              stop;
    logic              dir;
    logic [2**N-1:0]   a_out;
    logic [N-1:0]      amt_out;
    logic              running;
    logic              step_pulse;
    logic              rev_done;

    modport master (
        output load, din, start, stop, dir,
        input  a_out, amt_out, running, step_pulse, rev_done
    );

    modport slave (
        input  load, din, start, stop, dir,
        output a_out, amt_out, running, step_pulse, rev_done
    );

endinterface

// File: rtl/rot_step_sequencer_tick_gen.sv
// Mod-TICK_DIV prescaler: counts while enabled, freezes otherwise, and
// flags the last count of each interval so the owner can step on the wrap.
module tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic max_tick_o
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign max_tick_o = en_i && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance/wrap only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rot_step_sequencer.sv
// Upstream control stage for the right rotator: holds the data word and
// steps the rotation amount at a programmable rate under run/pause control.
module rot_step_sequencer
    import rot_seq_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    rot_step_sequencer_if.slave  ctrl
);

    localparam int unsigned W = 2**N;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [N-1:0]   amt_q, amt_d;
    logic           running_q, running_d;
    logic           step_q, step_d;
    logic           rev_q, rev_d;
    logic           run_en;
    logic           max_tick;

    assign run_en = (state_q == RUN);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst        (reset),
        .en_i       (run_en),
        .clr_i      (ctrl.load),
        .max_tick_o (max_tick)
    );

    // Next state and outputs; load overrides everything, a step still
    // happens on the stop cycle because stepping is gated only by load.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        amt_d   = amt_q;
        step_d  = 1'b0;
        rev_d   = 1'b0;
        if (ctrl.load) begin
            state_d = IDLE;
            a_d     = ctrl.din;
            amt_d   = '0;
        end else begin
            case (state_q)
                IDLE:    if (ctrl.start && !ctrl.stop) state_d = RUN;
                RUN:     if (ctrl.stop)                state_d = PAUSE;
                PAUSE:   if (ctrl.start && !ctrl.stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
            if (max_tick) begin
                step_d = 1'b1;
                if (ctrl.dir) begin
                    amt_d = amt_q - N'(1);
                    rev_d = (amt_q == '0);
                end else begin
                    amt_d = amt_q + N'(1);
                    rev_d = (amt_q == '1);
                end
            end
        end
        running_d = (state_d == RUN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            amt_q     <= '0;
            running_q <= 1'b0;
            step_q    <= 1'b0;
            rev_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            amt_q     <= amt_d;
            running_q <= running_d;
            step_q    <= step_d;
            rev_q     <= rev_d;
        end
    end

    assign ctrl.a_out      = a_q;
    assign ctrl.amt_out    = amt_q;
    assign ctrl.running    = running_q;
    assign ctrl.step_pulse = step_q;
    assign ctrl.rev_done   = rev_q;

endmodule

// File: tb/tb_rot_step_sequencer.sv
// Directed bench for rot_step_sequencer with TICK_DIV = 4, N = 3.
module tb_rot_step_sequencer;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    rot_step_sequencer_if #(.N(3)) bus ();

    rot_step_sequencer #(
        .N        (3),
        .TICK_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] din;
        logic       st;
        logic       sp;
        logic       dr;
        logic [7:0] ea;
        logic [2:0] eamt;
        logic       erun;
        logic       estep;
        logic       erev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [7:0] din,
                                input logic st, input logic sp, input logic dr,
                                input logic [7:0] ea, input logic [2:0] eamt,
                                input logic erun, input logic estep, input logic erev);
        vec_t v;
        v.ld = ld; v.din = din; v.st = st; v.sp = sp; v.dr = dr;
        v.ea = ea; v.eamt = eamt; v.erun = erun; v.estep = estep; v.erev = erev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ea, input logic [2:0] eamt,
                           input logic erun, input logic estep, input logic erev);
        chk({tag, ".a_out"},      32'(bus.a_out),      32'(ea));
        chk({tag, ".amt_out"},    32'(bus.amt_out),    32'(eamt));
        chk({tag, ".running"},    32'(bus.running),    32'(erun));
        chk({tag, ".step_pulse"}, 32'(bus.step_pulse), 32'(estep));
        chk({tag, ".rev_done"},   32'(bus.rev_done),   32'(erev));
    endtask

    // Drive one cycle of inputs; pulses drop right after the edge.
    task automatic cyc(input logic ld, input logic [7:0] din, input logic st,
                       input logic sp, input logic dr);
        bus.load  = ld;
        bus.din   = din;
        bus.start = st;
        bus.stop  = sp;
        bus.dir   = dr;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Basic up run: load A5, start, 8 steps with wrap on the last.
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 8'hA5, 3'd0, 0, 0, 0));
        vecs.push_back(mk(0, 8'hA5, 1, 0, 0, 8'hA5, 3'd0, 1, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            for (int q = 0; q < 3; q++)
                vecs.push_back(mk(0, 8'hA5, 0, 0, 0, 8'hA5, 3'(k - 1), 1, 0, 0));
            vecs.push_back(mk(0, 8'hA5, 0, 0, 0, 8'hA5, 3'(k % 8), 1, 1, (k == 8)));
        end
        // Back to IDLE; start+stop together from IDLE does nothing.
        vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 8'h5A, 3'd0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h5A, 1, 1, 0, 8'h5A, 3'd0, 0, 0, 0));
        // Down run: 0 -> 7 with rev_done, then 6 without.
        vecs.push_back(mk(0, 8'h5A, 1, 0, 1, 8'h5A, 3'd0, 1, 0, 0));
        for (int q = 0; q < 3; q++)
            vecs.push_back(mk(0, 8'h5A, 0, 0, 1, 8'h5A, 3'd0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h5A, 0, 0, 1, 8'h5A, 3'd7, 1, 1, 1));
        for (int q = 0; q < 3; q++)
            vecs.push_back(mk(0, 8'h5A, 0, 0, 1, 8'h5A, 3'd7, 1, 0, 0));
        vecs.push_back(mk(0, 8'h5A, 0, 0, 1, 8'h5A, 3'd6, 1, 1, 0));
        // dir flips back to up only for the step edge: 6 -> 7.
        for (int q = 0; q < 3; q++)
            vecs.push_back(mk(0, 8'h5A, 0, 0, 1, 8'h5A, 3'd6, 1, 0, 0));
        vecs.push_back(mk(0, 8'h5A, 0, 0, 0, 8'h5A, 3'd7, 1, 1, 0));

        // Reset state before any clock edge.
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.din   = '0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.dir   = 1'b0;
        #2;
        chk_out("reset_initial", 8'h00, 3'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("reset_held", 8'h00, 3'd0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ld, vecs[i].din, vecs[i].st, vecs[i].sp, vecs[i].dr);
            chk_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eamt,
                    vecs[i].erun, vecs[i].estep, vecs[i].erev);
        end

        // Pause/resume: freeze at amt=3 with count 2, resume needs 2 cycles.
        cyc(1, 8'hC3, 0, 0, 0);
        chk_out("pr_load", 8'hC3, 3'd0, 0, 0, 0);
        cyc(0, 8'hC3, 1, 0, 0);
        chk_out("pr_start", 8'hC3, 3'd0, 1, 0, 0);
        repeat (11) cyc(0, 8'hC3, 0, 0, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        chk_out("pr_at3", 8'hC3, 3'd3, 1, 1, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        cyc(0, 8'hC3, 0, 1, 0);
        chk_out("pr_stop", 8'hC3, 3'd3, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 8'hC3, 0, 0, 0);
            chk_out($sformatf("pr_hold%0d", i), 8'hC3, 3'd3, 0, 0, 0);
        end
        cyc(0, 8'hC3, 1, 0, 0);
        chk_out("pr_resume0", 8'hC3, 3'd3, 1, 0, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        chk_out("pr_resume1", 8'hC3, 3'd3, 1, 0, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        chk_out("pr_resume2", 8'hC3, 3'd4, 1, 1, 0);

        // Stop on the wrap cycle: one step still happens, then frozen.
        cyc(0, 8'hC3, 0, 0, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        cyc(0, 8'hC3, 0, 0, 0);
        chk_out("col_pre", 8'hC3, 3'd4, 1, 0, 0);
        cyc(0, 8'hC3, 0, 1, 0);
        chk_out("col_step", 8'hC3, 3'd5, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 8'hC3, 0, 0, 0);
            chk_out($sformatf("col_hold%0d", i), 8'hC3, 3'd5, 0, 0, 0);
        end

        // load+start+stop on a step edge: load wins, step discarded.
        cyc(0, 8'hC3, 1, 0, 0);
        chk_out("pri_run", 8'hC3, 3'd5, 1, 0, 0);
        repeat (3) cyc(0, 8'hC3, 0, 0, 0);
        cyc(1, 8'h3C, 1, 1, 0);
        chk_out("pri_load", 8'h3C, 3'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 8'h00, 0, 0, 0);
            chk_out($sformatf("pri_idle%0d", i), 8'h3C, 3'd0, 0, 0, 0);
        end

        // Asynchronous reset mid-cycle while step_pulse is high.
        cyc(0, 8'h00, 1, 0, 0);
        repeat (4) cyc(0, 8'h00, 0, 0, 0);
        chk_out("ar_before", 8'h3C, 3'd1, 1, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        chk_out("ar_immediate", 8'h00, 3'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("ar_held", 8'h00, 3'd0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 8'h00, 0, 0, 0);
        chk_out("ar_released", 8'h00, 3'd0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        chk_out("ar_restart", 8'h00, 3'd0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
